// File: rtl/controlunit_multicycle_if.sv
// Bundle between the multicycle LEGv8 control unit and the shared datapath.
// The control unit is the master: it receives the opcode and the two memory
// handshakes and drives every datapath control and sequencing strobe.
interface controlunit_multicycle_if #(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
);
    // Instruction register and memory handshake inputs
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                mem_ready;

    // Sequencing strobes
    logic                ir_write;
    logic                pc_write;

    // Datapath controls
    logic                Reg2Loc;
    logic                UBranch;
    logic                Branch;
    logic                MemRead;
    logic                MemtoReg;
    logic                MemWrite;
    logic                ALUsrc;
    logic                RegWrite;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                flag_write;
    logic                mul_start;

    // Status
    logic                illegal;
    logic [CNT_W-1:0]    retired;

    // Control unit side
    modport master (
        input  opcode, instr_valid, mem_ready,
        output ir_write, pc_write, Reg2Loc, UBranch, Branch, MemRead,
               MemtoReg, MemWrite, ALUsrc, RegWrite, ALUOp, flag_write,
               mul_start, illegal, retired
    );

    // Datapath / instruction-fetch side
    modport slave (
        output opcode, instr_valid, mem_ready,
        input  ir_write, pc_write, Reg2Loc, UBranch, Branch, MemRead,
               MemtoReg, MemWrite, ALUsrc, RegWrite, ALUOp, flag_write,
               mul_start, illegal, retired
    );
endinterface

// File: rtl/controlunit_multicycle.sv
// Multicycle LEGv8 control unit.
// Walks each instruction through FETCH/DECODE/EXEC and then MULWAIT, MEM
// and/or WB as the instruction class needs, driving the datapath controls
// for each step. Unknown opcodes park the unit in TRAP until reset, and a
// counter tallies every instruction that retires (every pc_write cycle).
module controlunit_multicycle #(
    parameter int OPCODE_W   = 11,
    parameter int ALUOP_W    = 3,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    controlunit_multicycle_if.master bus
);

    // Multiplier wait counter only has to hold MUL_CYCLES-1 down to 0
    localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_CYCLES - 1);

    // ALU operation codes understood by the shared ALU
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_LSL   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_LSR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_MUL   = ALUOP_W'(6);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MULWAIT,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_NONE,
        C_ADDI,
        C_ADDS,
        C_SUBS,
        C_B,
        C_BLT,
        C_CBZ,
        C_LDUR,
        C_STUR,
        C_LSL,
        C_LSR,
        C_MUL,
        C_ILLEGAL
    } class_e;

    state_e           r_state;
    class_e           r_class;
    logic [MCW-1:0]   r_mulCount;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    class_e             w_decoded;
    logic               w_irWrite;
    logic               w_pcWrite;
    logic               w_reg2Loc;
    logic               w_uBranch;
    logic               w_branch;
    logic               w_memRead;
    logic               w_memToReg;
    logic               w_memWrite;
    logic               w_aluSrc;
    logic               w_regWrite;
    logic [ALUOP_W-1:0] w_aluOp;
    logic               w_flagWrite;
    logic               w_mulStart;

    // Opcode classification; the first matching pattern wins, so the order
    // of the entries below is the decode priority
    function automatic class_e decodeOpcode(input logic [10:0] op);
        class_e c;
        casez (op)
            11'b1001000100?: c = C_ADDI;
            11'b10101011000: c = C_ADDS;
            11'b11101011000: c = C_SUBS;
            11'b000101?????: c = C_B;
            11'b01010100???: c = C_BLT;
            11'b10110100???: c = C_CBZ;
            11'b11111000010: c = C_LDUR;
            11'b11111000000: c = C_STUR;
            11'b11010011011: c = C_LSL;
            11'b11010011010: c = C_LSR;
            11'b10011011000: c = C_MUL;
            default:         c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    assign w_decoded = decodeOpcode(bus.opcode[10:0]);

    // Sequencer: state, latched instruction class, multiplier wait counter,
    // sticky trap flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_class    <= C_NONE;
            r_mulCount <= '0;
            r_illegal  <= 1'b0;
            r_retired  <= '0;
        end else begin
            if (w_pcWrite) begin
                r_retired <= r_retired + 1'b1;
            end
            case (r_state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_class <= w_decoded;
                    if (w_decoded == C_ILLEGAL) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_class)
                        C_LDUR, C_STUR:   r_state <= S_MEM;
                        C_B, C_BLT, C_CBZ: r_state <= S_FETCH;
                        C_MUL: begin
                            r_state    <= S_MULWAIT;
                            r_mulCount <= MUL_LOAD;
                        end
                        default:          r_state <= S_WB;
                    endcase
                end
                S_MULWAIT: begin
                    if (r_mulCount == '0) begin
                        r_state <= S_WB;
                    end else begin
                        r_mulCount <= r_mulCount - 1'b1;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= (r_class == C_STUR) ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Control decode from state and class. ir_write in FETCH and the STUR
    // pc_write in MEM are qualified by their handshake in the same cycle so
    // accepted words and completed stores cost no extra cycle; everything
    // else depends only on the registered state and class. Reset forces all
    // controls low.
    always_comb begin
        w_irWrite   = 1'b0;
        w_pcWrite   = 1'b0;
        w_reg2Loc   = 1'b0;
        w_uBranch   = 1'b0;
        w_branch    = 1'b0;
        w_memRead   = 1'b0;
        w_memToReg  = 1'b0;
        w_memWrite  = 1'b0;
        w_aluSrc    = 1'b0;
        w_regWrite  = 1'b0;
        w_aluOp     = ALU_PASSB;
        w_flagWrite = 1'b0;
        w_mulStart  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    w_irWrite = bus.instr_valid;
                end
                S_EXEC: begin
                    case (r_class)
                        C_ADDI: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_ADD;
                        end
                        C_ADDS: begin
                            w_aluOp     = ALU_ADD;
                            w_flagWrite = 1'b1;
                        end
                        C_SUBS: begin
                            w_aluOp     = ALU_SUB;
                            w_flagWrite = 1'b1;
                        end
                        C_LSL: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_LSL;
                        end
                        C_LSR: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_LSR;
                        end
                        C_LDUR: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_ADD;
                        end
                        C_STUR: begin
                            w_aluSrc  = 1'b1;
                            w_aluOp   = ALU_ADD;
                            w_reg2Loc = 1'b1;
                        end
                        C_B: begin
                            w_uBranch = 1'b1;
                            w_pcWrite = 1'b1;
                        end
                        C_BLT: begin
                            w_branch  = 1'b1;
                            w_pcWrite = 1'b1;
                        end
                        C_CBZ: begin
                            w_reg2Loc = 1'b1;
                            w_branch  = 1'b1;
                            w_pcWrite = 1'b1;
                        end
                        C_MUL: begin
                            w_aluOp    = ALU_MUL;
                            w_mulStart = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MULWAIT: begin
                    w_aluOp = ALU_MUL;
                end
                S_MEM: begin
                    if (r_class == C_LDUR) begin
                        w_memRead  = 1'b1;
                        w_memToReg = 1'b1;
                    end else begin
                        w_memWrite = 1'b1;
                        w_reg2Loc  = 1'b1;
                        w_aluSrc   = 1'b1;
                        w_pcWrite  = bus.mem_ready;
                    end
                end
                S_WB: begin
                    w_regWrite = 1'b1;
                    w_pcWrite  = 1'b1;
                    case (r_class)
                        C_LDUR: w_memToReg = 1'b1;
                        C_ADDI: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_ADD;
                        end
                        C_ADDS: w_aluOp = ALU_ADD;
                        C_SUBS: w_aluOp = ALU_SUB;
                        C_LSL: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_LSL;
                        end
                        C_LSR: begin
                            w_aluSrc = 1'b1;
                            w_aluOp  = ALU_LSR;
                        end
                        C_MUL:  w_aluOp = ALU_MUL;
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ir_write   = w_irWrite;
    assign bus.pc_write   = w_pcWrite;
    assign bus.Reg2Loc    = w_reg2Loc;
    assign bus.UBranch    = w_uBranch;
    assign bus.Branch     = w_branch;
    assign bus.MemRead    = w_memRead;
    assign bus.MemtoReg   = w_memToReg;
    assign bus.MemWrite   = w_memWrite;
    assign bus.ALUsrc     = w_aluSrc;
    assign bus.RegWrite   = w_regWrite;
    assign bus.ALUOp      = w_aluOp;
    assign bus.flag_write = w_flagWrite;
    assign bus.mul_start  = w_mulStart;
    assign bus.illegal    = r_illegal & ~reset;
    assign bus.retired    = reset ? '0 : r_retired;

endmodule

// File: doc/controlunit_multicycle.md
Name: controlunit_multicycle

Overview:
Parametrised multicycle successor to the single-cycle LEGv8 control decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and drives the same datapath control set plus sequencing strobes. It adds a multi-cycle MUL wait, a memory ready handshake, real LSL/LSR/MUL ALU codes, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and the shared ALU/regfile/data-memory datapath.

Parameters:
OPCODE_W, 11, opcode field width (instr[31:21]); fixed encodings below assume 11
ALUOP_W, 3, width of ALUOp
MUL_CYCLES, 4, cycles spent in MULWAIT (legal range >=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  instr[31:21], sampled only in DECODE
instr_valid  in  1  instruction memory has valid word
mem_ready  in  1  data memory completes the current access this cycle
ir_write  out  1  load instruction register
pc_write  out  1  update PC (datapath selects PC+4 / branch target using Branch, UBranch, flags)
Reg2Loc, UBranch, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite  out  1 each  datapath controls
ALUOp  out  ALUOP_W  000 pass-B, 010 add, 011 sub, 100 lsl, 101 lsr, 110 mul
flag_write  out  1  latch NZCV (ADDS/SUBS only, in EXEC)
mul_start  out  1  one-cycle pulse starting multiplier
illegal  out  1  sticky trap flag
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (synchronous, active-high): state=FETCH, instruction-class reg=NONE, mul counter=0, illegal=0, retired=0. All outputs are 0 during and after reset until the FSM drives them. Reset in any state, including MULWAIT/MEM/TRAP, abandons the instruction with no pc_write and no RegWrite.
- Decode in DECODE, in this priority order, latched into the class reg:
  - ADDI: opcode[10:1]=1001000100
  - ADDS: 10101011000
  - SUBS: 11101011000
  - B: opcode[10:5]=000101
  - B.LT: opcode[10:3]=01010100
  - CBZ: opcode[10:3]=10110100
  - LDUR: 11111000010
  - STUR: 11111000000
  - LSL: 11010011011
  - LSR: 11010011010
  - MUL: 10011011000
  - anything else: ILLEGAL
- Outputs are a Moore function of the state reg and the class reg; opcode has no path to outputs outside DECODE. Every output not listed for a state is 0; no X values are driven.
- FETCH: if instr_valid, ir_write=1 and go to DECODE; else stay.
- DECODE: latch class. ILLEGAL goes to TRAP; everything else goes to EXEC.
- EXEC, per class:
  - ADDI: ALUsrc=1, ALUOp=010.
  - ADDS/SUBS: Reg2Loc=0, ALUOp=010/011, flag_write=1.
  - LSL/LSR: ALUsrc=1, ALUOp=100/101.
  - LDUR/STUR: ALUsrc=1, ALUOp=010; STUR also Reg2Loc=1.
  - All of the above go to WB, except LDUR/STUR, which go to MEM.
  - B: UBranch=1, pc_write=1, go to FETCH.
  - B.LT: Branch=1, pc_write=1, go to FETCH.
  - CBZ: Reg2Loc=1, ALUOp=000, Branch=1, pc_write=1, go to FETCH.
  - MUL: ALUOp=110, mul_start=1, counter loaded MUL_CYCLES-1, go to MULWAIT.
- MULWAIT: ALUOp=110 held. Counter decrements each cycle; at 0, go to WB. Occupancy is exactly MUL_CYCLES cycles.
- MEM: LDUR holds MemRead=1, MemtoReg=1; STUR holds MemWrite=1, Reg2Loc=1, ALUsrc=1. Stay in MEM while mem_ready=0 (no timeout). On mem_ready=1: LDUR goes to WB; STUR asserts pc_write=1 and goes to FETCH.
- WB: RegWrite=1, pc_write=1, go to FETCH. MemtoReg=1 for LDUR; ALUsrc/ALUOp are held as in EXEC for non-loads.
- TRAP: illegal=1, all controls 0, no pc_write. Stays in TRAP until reset.
- retired increments by 1 in every cycle pc_write=1 and wraps modulo 2^CNT_W.
- Latency, from FETCH accept (instr_valid high) to the pc_write cycle:
  - ALU ops: 4 cycles (F,D,E,WB)
  - branches: 3 cycles
  - STUR: 4 cycles + mem wait
  - LDUR: 5 cycles + mem wait
  - MUL: 4 + MUL_CYCLES cycles
- Simultaneous events: reset has priority over everything. instr_valid is ignored outside FETCH; mem_ready is ignored outside MEM.

Test Plan:
- Reset then ADDS (10101011000), instr_valid held 1 -> ir_write@c0, flag_write&ALUOp=010@c2, RegWrite&pc_write@c3, retired=1; no output X at any cycle.
- LDUR with mem_ready low 2 cycles -> MemRead=1 for 3 MEM cycles, then WB with MemtoReg=1, RegWrite=1; total 7 cycles; STUR same wait -> MemWrite 3 cycles, pc_write in last MEM cycle, RegWrite never 1.
- MUL (10011011000), MUL_CYCLES=4 -> mul_start pulse exactly 1 cycle @c2, MULWAIT 4 cycles, RegWrite@c7; rerun with MUL_CYCLES=1 -> RegWrite@c4.
- B, B.LT, CBZ back-to-back -> each 3 cycles, UBranch/Branch with pc_write in EXEC, CBZ Reg2Loc=1 ALUOp=000, retired=3.
- Opcode 11'h000 -> illegal=1 from cycle after DECODE, stays 1 with instr_valid toggling 20 cycles, retired unchanged; reset clears to FETCH, illegal=0.
- Reset asserted in 2nd MULWAIT cycle -> next cycle FETCH, no RegWrite/pc_write, retired unchanged; retired preloaded near 2^CNT_W-1 (CNT_W=4 build) wraps 15 -> 0.
